ex_hazard_scheduler: RTL and testbench
======================================

Name: ex_hazard_scheduler

Overview:
- Hazard and forwarding controller for the execution stage.
- Tracks the destination registers of instructions in flight across the EX, MEM and WB stages.
- Drives the two execute-stage operand source selects, and stalls the decode stage on load-use hazards.
- Inserts bubbles on stall and branch flush, honours the global memory freeze, and keeps a saturating stall counter.

Parameters:
- RA_W, 4, register-address width (16 architectural registers).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- freeze  input  1  global pipeline freeze (memory wait); all state holds.
- br_taken  input  1  branch resolved taken in EX this cycle; flushes the decode instruction.
- id_valid  input  1  decode stage holds a real instruction.
- id_src1  input  RA_W  first source register (Rn).
- id_src2  input  RA_W  second source register (Rm, or Rd for store data).
- id_use1  input  1  instruction reads id_src1.
- id_use2  input  1  instruction reads id_src2.
- id_dest  input  RA_W  destination register.
- id_wb_en  input  1  instruction writes id_dest.
- id_mem_r  input  1  instruction is a load.
- stall  output  1  hold PC and the IF/ID register this cycle (combinational).
- sel_src_1  output  2  EX operand-1 select: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result.
- sel_src_2  output  2  EX operand-2 select, same encoding.
- ex_valid  output  1  EX stage holds a real (non-bubble) instruction.
- stall_cnt  output  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Internal stage records EX, MEM, WB; each holds {valid, wb_en, mem_r, dest}.
- Reset clears all records, sel_src_1 = sel_src_2 = 0, ex_valid = 0, stall_cnt = 0.
- match(s, R): asserted when use_s = 1, R.valid = 1, R.wb_en = 1 and src_s == R.dest.
- stall (combinational) = id_valid & !br_taken & (match(1, EX) | match(2, EX)) & EX.mem_r.
  - Load-use hazard costs exactly 1 bubble.
  - Register 15 is not special-cased.
- Register file is write-before-read, so a WB-stage writer never causes a hazard.
- Each rising edge with freeze = 0:
  - MEM <= EX and WB <= MEM.
  - If br_taken or stall: EX <= bubble (valid = 0), sel_src_1 = sel_src_2 = 0.
  - Otherwise: EX <= {id_valid, id_wb_en, id_mem_r, id_dest}.
  - Operand select on issue, for each operand s: match(s, EX) gives 1; else match(s, MEM) gives 2; else 0.
  - The youngest writer (old EX, now MEM) wins over the older one.
- freeze = 1: every record, select and counter holds; stall is still computed from the held state.
- br_taken has priority over stall; stall_cnt does not increment on a cycle where br_taken is high.
- stall_cnt increments on each rising edge with stall = 1 and freeze = 0, and saturates at all-ones.
- ex_valid = EX.valid.
- Selects are registered, so they are stable for the whole EX cycle.
- Reset mid-operation clears all records immediately, with no partial commit.

Optional Feature:
- Macro: EX_HAZARD_FWD_EN.
- Defined: forwarding behaves as described under Behaviour.
- Undefined:
  - sel_src_1 and sel_src_2 are tied to 0.
  - stall = id_valid & !br_taken & (match(1, EX) | match(2, EX) | match(1, MEM) | match(2, MEM)), regardless of mem_r.
  - A dependent instruction therefore waits up to 2 cycles.

Test Plan:
- ADD R1 issued, then SUB R2, R1, R3 next cycle, FWD_EN → no stall; sel_src_1 = 1 during SUB's EX cycle.
- ADD R1; unrelated instruction; ORR R4, R5, R1 → sel_src_2 = 2 during ORR's EX cycle, sel_src_1 = 0.
- LDR R1; then ADD R2, R1, R1 →
  - stall = 1 for exactly 1 cycle, one bubble (ex_valid = 0), stall_cnt goes 0 → 1.
  - ADD then issues with sel_src_1 = sel_src_2 = 2.
- LDR R1 while a dependent instruction is in decode, with freeze = 1 for 3 cycles → stall held high, records and stall_cnt frozen; exactly one increment after freeze drops.
- Load-use hazard in decode with br_taken = 1 in the same cycle → stall = 0, EX becomes a bubble, stall_cnt unchanged.
- FWD_EN undefined: ADD R1 then SUB R2, R1, R3 → stall for 2 cycles, selects 0, stall_cnt = 2.
  - Also assert rst mid-stall → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/ex_hazard_scheduler.sv
// Execute-stage hazard/forwarding controller. It tracks EX/MEM/WB writers, registers the operand selects and stalls decode on hazards.
// The EX_HAZARD_FWD_EN macro enables forwarding. When it is undefined, the selects are 0 and dependents wait until the writer leaves MEM.
module ex_hazard_scheduler #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             br_taken,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r,
  output logic             stall,
  output logic [1:0]       sel_src_1,
  output logic [1:0]       sel_src_2,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic            wb_en;
    logic            mem_r;
    logic [RA_W-1:0] dest;
  } rec_t;

  rec_t ex_q, mem_q, wb_q, id_rec;
  logic [CNT_W-1:0] cnt_q;
  logic h1_ex, h2_ex, h1_mem, h2_mem;

  function automatic logic hit(input logic use_s, input logic [RA_W-1:0] src, input rec_t r);
    return use_s & r.valid & r.wb_en & (src == r.dest);
  endfunction

  assign id_rec = {id_valid, id_wb_en, id_mem_r, id_dest};
  assign h1_ex  = hit(id_use1, id_src1, ex_q);
  assign h2_ex  = hit(id_use2, id_src2, ex_q);
  assign h1_mem = hit(id_use1, id_src1, mem_q);
  assign h2_mem = hit(id_use2, id_src2, mem_q);

`ifdef EX_HAZARD_FWD_EN
  logic [1:0] sel1_q, sel2_q;
  logic       unused_rec;

  // Only a load still in EX cannot be forwarded in time; everything else is bypassed.
  assign stall = id_valid & ~br_taken & (h1_ex | h2_ex) & ex_q.mem_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel1_q <= 2'd0;
      sel2_q <= 2'd0;
    end else if (!freeze) begin
      if (br_taken || stall) begin
        sel1_q <= 2'd0;
        sel2_q <= 2'd0;
      end else begin
        // Youngest writer (current EX, becoming MEM) takes priority.
        sel1_q <= h1_ex ? 2'd1 : (h1_mem ? 2'd2 : 2'd0);
        sel2_q <= h2_ex ? 2'd1 : (h2_mem ? 2'd2 : 2'd0);
      end
    end
  end

  assign sel_src_1  = sel1_q;
  assign sel_src_2  = sel2_q;
  assign unused_rec = ^{wb_q, mem_q.mem_r};
`else
  logic unused_rec;

  assign stall      = id_valid & ~br_taken & (h1_ex | h2_ex | h1_mem | h2_mem);
  assign sel_src_1  = 2'd0;
  assign sel_src_2  = 2'd0;
  assign unused_rec = ^{wb_q, mem_q.mem_r, ex_q.mem_r};
`endif

  // The register file writes before it reads, so the WB record never causes a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (br_taken || stall) ? rec_t'('0) : id_rec;
      if (stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid  = ex_q.valid;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Directed bench for ex_hazard_scheduler. It drives one instruction per cycle and checks stall immediately. Registered outputs are checked after the next edge through a queue.
module tb_ex_hazard_scheduler;

`ifdef EX_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0, br_taken = 1'b0, id_valid = 1'b0;
  logic [3:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic        id_use1 = 1'b0, id_use2 = 1'b0, id_wb_en = 1'b0, id_mem_r = 1'b0;
  logic        stall, ex_valid;
  logic [1:0]  sel_src_1, sel_src_2;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];

  ex_hazard_scheduler #(.RA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .stall(stall),
    .sel_src_1(sel_src_1), .sel_src_2(sel_src_2), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string t, input logic [20:0] got, input logic [20:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, got, exp);
    end
  endtask

  task automatic compare_pending();
    logic [20:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/regs"}, {sel_src_1, sel_src_2, ex_valid, stall_cnt}, e);
    end
  endtask

  // One decode cycle: check stall now, queue the registered outputs expected after the edge.
  task automatic cyc(input string t, input bit frz, input bit br, input bit v,
                     input logic [3:0] s1, input bit u1, input logic [3:0] s2, input bit u2,
                     input logic [3:0] d, input bit we, input bit ld,
                     input bit es, input logic [1:0] e1, input logic [1:0] e2,
                     input bit ev, input logic [15:0] ec);
    @(negedge clk);
    compare_pending();
    freeze = frz; br_taken = br; id_valid = v;
    id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_dest = d; id_wb_en = we; id_mem_r = ld;
    #1;
    check({t, "/stall"}, 21'(stall), 21'(es));
    exp_q.push_back({e1, e2, ev, ec});
    tag_q.push_back(t);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset/regs", {sel_src_1, sel_src_2, ex_valid, stall_cnt}, 21'd0);
    check("reset/stall", 21'(stall), 21'd0);

`ifdef EX_HAZARD_FWD_EN
    //     tag          frz br v  s1 u1 s2 u2 d  we ld  st s1 s2 ev cnt
    cyc("add_r1",       0, 0, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0);
    cyc("sub_fwd_mem",  0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  0, 1, 0, 1, 0);
    cyc("mov_r1",       0, 0, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0);
    cyc("unrelated",    0, 0, 1, 0, 0, 0, 0, 9, 1, 0,  0, 0, 0, 1, 0);
    cyc("orr_fwd_wb",   0, 0, 1, 5, 1, 1, 1, 4, 1, 0,  0, 0, 2, 1, 0);
    cyc("ldr_r1",       0, 0, 1, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 1, 0);
    cyc("ld_use",       0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 0, 0, 0, 1);
    cyc("ld_use_issue", 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  0, 2, 2, 1, 1);
    cyc("ldr_r3",       0, 0, 1, 0, 0, 0, 0, 3, 1, 1,  0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      cyc("frz",        1, 0, 1, 3, 1, 0, 0, 4, 1, 0,  1, 0, 0, 1, 1);
    cyc("unfrz",        0, 0, 1, 3, 1, 0, 0, 4, 1, 0,  1, 0, 0, 0, 2);
    cyc("frz_issue",    0, 0, 1, 3, 1, 0, 0, 4, 1, 0,  0, 2, 0, 1, 2);
    cyc("ldr_r7",       0, 0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0, 1, 2);
    cyc("br_flush",     0, 1, 1, 7, 1, 7, 1, 8, 1, 0,  0, 0, 0, 0, 2);
    cyc("nop",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    cyc("ldr_r9",       0, 0, 1, 0, 0, 0, 0, 9, 1, 1,  0, 0, 0, 1, 2);
    cyc("dep_r9",       0, 0, 1, 9, 1, 0, 0,10, 1, 0,  1, 0, 0, 0, 3);
`else
    cyc("add_r1",       0, 0, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0);
    cyc("sub_dep_ex",   0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, 0, 1);
    cyc("sub_dep_mem",  0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, 0, 2);
    cyc("sub_issue",    0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  0, 0, 0, 1, 2);
    cyc("nop",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    cyc("add_r4",       0, 0, 1, 0, 0, 0, 0, 4, 1, 0,  0, 0, 0, 1, 2);
    for (int i = 0; i < 3; i++)
      cyc("frz",        1, 0, 1, 6, 1, 4, 1, 5, 1, 0,  1, 0, 0, 1, 2);
    cyc("unfrz",        0, 0, 1, 6, 1, 4, 1, 5, 1, 0,  1, 0, 0, 0, 3);
    cyc("dep_mem",      0, 0, 1, 6, 1, 4, 1, 5, 1, 0,  1, 0, 0, 0, 4);
    cyc("orr_issue",    0, 0, 1, 6, 1, 4, 1, 5, 1, 0,  0, 0, 0, 1, 4);
    cyc("ldr_r7",       0, 0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0, 1, 4);
    cyc("br_flush",     0, 1, 1, 7, 1, 7, 1, 8, 1, 0,  0, 0, 0, 0, 4);
    cyc("nop2",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4);
    cyc("add_r9",       0, 0, 1, 0, 0, 0, 0, 9, 1, 0,  0, 0, 0, 1, 4);
    cyc("dep_r9",       0, 0, 1, 9, 1, 0, 0,10, 1, 0,  1, 0, 0, 0, 5);
`endif

    // Mid-cycle asynchronous reset with a dependent instruction still in decode.
    @(negedge clk);
    compare_pending();
    #1;
    check("pre_rst/stall", 21'(stall), 21'(!FWD));
    #1;
    rst = 1'b1;
    #1;
    check("async_rst/regs", {sel_src_1, sel_src_2, ex_valid, stall_cnt}, 21'd0);
    check("async_rst/stall", 21'(stall), 21'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst",     0, 0, 1, 9, 1, 0, 0,10, 1, 0,  0, 0, 0, 1, 0);
    @(negedge clk);
    compare_pending();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
